// File: rtl/sound_effect_sequencer.sv
// sound_effect_sequencer: plays one of four fixed multi-note square-wave effects on a Trigger rising edge.
module sound_effect_sequencer #(
  parameter int unsigned TICK_DIV = 25000
) (
  input  logic       clk25,
  input  logic       Reset,
  input  logic       Trigger,
  input  logic [1:0] Choice,
  output logic       Speaker,
  output logic       Busy,
  output logic [1:0] NoteIdx
);
  typedef enum logic {IDLE, PLAY} state_t;
  state_t      r_state;
  logic        r_trig_d;
  logic [1:0]  r_eff;
  logic [1:0]  r_idx;
  logic        r_spk;
  logic [15:0] r_hp;
  logic [15:0] r_tick;
  logic [7:0]  r_dur;
  logic        w_edge;
  logic [15:0] w_hp;
  logic        w_last;
  logic        w_wrap;
  logic        w_expire;
  logic        w_toggle;
  function automatic logic [15:0] hp_of(input logic [1:0] e, input logic [1:0] i);
    return e[1] ? (e[0] ? (i == 2'd0 ? 16'd28409 : i == 2'd1 ? 16'd37879 : 16'd56818)
                        : (i == 2'd0 ? 16'd9470 : 16'd7102))
                : (e[0] ? 16'd14205 : 16'd12500);
  endfunction
  function automatic logic [7:0] dur_of(input logic [1:0] e, input logic [1:0] i);
    return e[1] ? (e[0] ? (i == 2'd2 ? 8'd200 : 8'd100) : 8'd60) : 8'd40;
  endfunction
  always_comb begin
    w_edge   = Trigger & ~r_trig_d;
    w_hp     = hp_of(r_eff, r_idx);
    w_last   = r_idx == (r_eff[1] ? (r_eff[0] ? 2'd2 : 2'd1) : 2'd0);
    w_wrap   = r_tick == 16'(TICK_DIV - 1);
    w_expire = w_wrap && r_dur == 8'd1;
    w_toggle = r_hp == w_hp - 16'd1;
  end
  always_ff @(posedge clk25) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_trig_d <= 1'b0;
      r_eff    <= 2'd0;
      r_idx    <= 2'd0;
      r_spk    <= 1'b0;
      r_hp     <= 16'd0;
      r_tick   <= 16'd0;
      r_dur    <= 8'd0;
    end else begin
      r_trig_d <= Trigger;
      if (w_edge) begin
        r_state <= PLAY;
        r_eff   <= Choice;
        r_idx   <= 2'd0;
        r_spk   <= 1'b0;
        r_hp    <= 16'd0;
        r_tick  <= 16'd0;
        r_dur   <= dur_of(Choice, 2'd0);
      end else if (r_state == PLAY) begin
        if (w_expire) begin
          r_spk  <= 1'b0;
          r_hp   <= 16'd0;
          r_tick <= 16'd0;
          r_state <= w_last ? IDLE : PLAY;
          r_idx  <= w_last ? 2'd0 : r_idx + 2'd1;
          r_dur  <= w_last ? 8'd0 : dur_of(r_eff, r_idx + 2'd1);
        end else begin
          r_hp   <= w_toggle ? 16'd0 : r_hp + 16'd1;
          r_spk  <= w_toggle ? ~r_spk : r_spk;
          r_tick <= w_wrap ? 16'd0 : r_tick + 16'd1;
          r_dur  <= w_wrap ? r_dur - 8'd1 : r_dur;
        end
      end
    end
  end
  assign Speaker = r_spk;
  assign Busy    = r_state == PLAY;
  assign NoteIdx = r_idx;
endmodule

// File: tb/tb_sound_effect_sequencer.sv
// tb_sound_effect_sequencer: vector table, speaker timing sequence and random run against an elapsed-time model.
module tb_sound_effect_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic [1:0] ch = 2'd0;
  logic       spk [2];
  logic       busy [2];
  logic [1:0] idx [2];
  int         checks = 0;
  int         failures = 0;
  int         c = 0;
  int         td [2] = '{2, 200};
  logic       m_busy [2] = '{1'b0, 1'b0};
  logic [1:0] m_eff [2] = '{2'd0, 2'd0};
  logic [1:0] m_idx [2] = '{2'd0, 2'd0};
  int         m_ns [2] = '{0, 0};
  logic       m_td = 1'b0;

  always #5 clk = ~clk;

  sound_effect_sequencer #(.TICK_DIV(2)) d0 (
    .clk25(clk), .Reset(rst), .Trigger(trig), .Choice(ch),
    .Speaker(spk[0]), .Busy(busy[0]), .NoteIdx(idx[0]));
  sound_effect_sequencer #(.TICK_DIV(200)) d1 (
    .clk25(clk), .Reset(rst), .Trigger(trig), .Choice(ch),
    .Speaker(spk[1]), .Busy(busy[1]), .NoteIdx(idx[1]));

  function automatic int hp_ref(input logic [1:0] e, input logic [1:0] i);
    int t [4][3] = '{'{12500, 0, 0}, '{14205, 0, 0}, '{9470, 7102, 0}, '{28409, 37879, 56818}};
    return t[e][i];
  endfunction
  function automatic int dur_ref(input logic [1:0] e, input logic [1:0] i);
    int t [4][3] = '{'{40, 0, 0}, '{40, 0, 0}, '{60, 60, 0}, '{100, 100, 200}};
    return t[e][i];
  endfunction
  function automatic int notes_ref(input logic [1:0] e);
    int t [4] = '{1, 1, 2, 3};
    return t[e];
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, got, exp, c);
    end
  endtask

  // One clock: advance the elapsed-time model, then compare both instances.
  task automatic cyc();
    logic edge_seen;
    @(posedge clk);
    c++;
    edge_seen = trig && !m_td;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_busy[k] = 1'b0;
        m_idx[k] = 2'd0;
        m_eff[k] = 2'd0;
      end else if (edge_seen) begin
        m_busy[k] = 1'b1;
        m_eff[k] = ch;
        m_idx[k] = 2'd0;
        m_ns[k] = c;
      end else if (m_busy[k] && c - m_ns[k] == dur_ref(m_eff[k], m_idx[k]) * td[k]) begin
        if (int'(m_idx[k]) == notes_ref(m_eff[k]) - 1) begin
          m_busy[k] = 1'b0;
          m_idx[k] = 2'd0;
        end else begin
          m_idx[k] = m_idx[k] + 2'd1;
          m_ns[k] = c;
        end
      end
    end
    m_td = rst ? 1'b0 : trig;
    #1;
    for (int k = 0; k < 2; k++) begin
      int exp_spk;
      exp_spk = m_busy[k] ? ((c - m_ns[k]) / hp_ref(m_eff[k], m_idx[k])) % 2 : 0;
      chk(k == 0 ? "model_fast" : "model_slow",
          {29'd0, spk[k], busy[k], idx[k]},
          {29'd0, exp_spk[0], m_busy[k], m_idx[k]});
    end
  endtask

  typedef struct {
    logic       rst;
    logic       trig;
    logic [1:0] ch;
    int         n;
    logic       eb;
    logic [1:0] ei;
  } vec_t;

  initial begin
    vec_t tv [$];
    tv.push_back('{1'b1, 1'b0, 2'd0,   3, 1'b0, 2'd0});
    tv.push_back('{1'b0, 1'b1, 2'd0,   1, 1'b1, 2'd0});
    tv.push_back('{1'b0, 1'b0, 2'd0,  79, 1'b1, 2'd0});
    tv.push_back('{1'b0, 1'b0, 2'd0,   1, 1'b0, 2'd0});
    tv.push_back('{1'b0, 1'b1, 2'd3,   1, 1'b1, 2'd0});
    tv.push_back('{1'b0, 1'b1, 2'd0, 199, 1'b1, 2'd0});
    tv.push_back('{1'b0, 1'b1, 2'd0,   1, 1'b1, 2'd1});
    tv.push_back('{1'b0, 1'b0, 2'd0, 200, 1'b1, 2'd2});
    tv.push_back('{1'b0, 1'b0, 2'd0, 399, 1'b1, 2'd2});
    tv.push_back('{1'b0, 1'b0, 2'd0,   1, 1'b0, 2'd0});
    tv.push_back('{1'b0, 1'b1, 2'd2,   1, 1'b1, 2'd0});
    tv.push_back('{1'b0, 1'b0, 2'd2, 130, 1'b1, 2'd1});
    tv.push_back('{1'b0, 1'b1, 2'd1,   1, 1'b1, 2'd0});
    tv.push_back('{1'b0, 1'b0, 2'd1,  79, 1'b1, 2'd0});
    tv.push_back('{1'b0, 1'b0, 2'd1,   1, 1'b0, 2'd0});
    tv.push_back('{1'b0, 1'b1, 2'd0,   1, 1'b1, 2'd0});
    tv.push_back('{1'b0, 1'b0, 2'd0,  79, 1'b1, 2'd0});
    tv.push_back('{1'b0, 1'b1, 2'd1,   1, 1'b1, 2'd0});
    tv.push_back('{1'b0, 1'b0, 2'd1,  79, 1'b1, 2'd0});
    tv.push_back('{1'b0, 1'b0, 2'd1,   1, 1'b0, 2'd0});
    tv.push_back('{1'b0, 1'b1, 2'd3,   1, 1'b1, 2'd0});
    tv.push_back('{1'b0, 1'b1, 2'd3, 250, 1'b1, 2'd1});
    tv.push_back('{1'b1, 1'b1, 2'd3,   1, 1'b0, 2'd0});
    tv.push_back('{1'b0, 1'b1, 2'd2,   1, 1'b1, 2'd0});
    tv.push_back('{1'b0, 1'b0, 2'd2, 120, 1'b1, 2'd1});
    tv.push_back('{1'b0, 1'b0, 2'd2, 120, 1'b0, 2'd0});
    tv.push_back('{1'b1, 1'b1, 2'd0,   1, 1'b0, 2'd0});
    tv.push_back('{1'b0, 1'b0, 2'd0,   2, 1'b0, 2'd0});
    for (int i = 0; i < tv.size(); i++) begin
      rst = tv[i].rst;
      trig = tv[i].trig;
      ch = tv[i].ch;
      repeat (tv[i].n) cyc();
      chk($sformatf("vec%0d_busy", i), int'(busy[0]), int'(tv[i].eb));
      chk($sformatf("vec%0d_idx", i), int'(idx[0]), int'(tv[i].ei));
    end
    // Score chime on the slow instance: one toggle per note, forced low at the note change.
    trig = 1'b1; ch = 2'd2;
    cyc();
    trig = 1'b0;
    repeat (9469) cyc();
    chk("chime_n0_pre", int'(spk[1]), 0);
    cyc();
    chk("chime_n0_rise", int'(spk[1]), 1);
    repeat (2529) cyc();
    chk("chime_n0_end_spk", int'(spk[1]), 1);
    chk("chime_n0_end_idx", int'(idx[1]), 0);
    cyc();
    chk("chime_n1_spk", int'(spk[1]), 0);
    chk("chime_n1_idx", int'(idx[1]), 1);
    repeat (7101) cyc();
    chk("chime_n1_pre", int'(spk[1]), 0);
    cyc();
    chk("chime_n1_rise", int'(spk[1]), 1);
    repeat (4898) cyc();
    chk("chime_done_busy", int'(busy[1]), 0);
    chk("chime_done_spk", int'(spk[1]), 0);
    for (int i = 0; i < 35000; i++) begin
      if ($urandom_range(0, i < 15000 ? 299 : 3999) == 0) trig = ~trig;
      ch = 2'($urandom);
      rst = $urandom_range(0, 3999) == 0;
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
